// File: rtl/example_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed-14 x unsigned-11 multiplier among NUM_REQ lanes.
// Optional per-requester accept counters are enabled by defining EXAMPLE_MUL_ARB_STATS_EN.
module example_mul_arb #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_STAGE = 3,
    parameter int ID_W      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
`ifdef EXAMPLE_MUL_ARB_STATS_EN
    input  logic                  stats_clr,
    input  logic [ID_W-1:0]       stats_sel,
    output logic [15:0]           stats_cnt,
`endif
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*14-1:0] req_a,
    input  logic [NUM_REQ*11-1:0] req_b,
    output logic [NUM_REQ-1:0]    res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [20:0]           res_p
);

    localparam int LAST = NUM_STAGE - 1;

    // Exact 25-bit product truncated to 21 bits, wrapping like the DSP core.
    function automatic logic [20:0] mul_wrap(input logic signed [13:0] a, input logic [10:0] b);
        logic signed [24:0] ax;
        logic signed [24:0] bx;
        logic signed [24:0] p;
        ax = 25'(a);
        bx = 25'($signed({1'b0, b}));
        p  = ax * bx;
        return p[20:0];
    endfunction

    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        rr_ptr_d;
    logic [2*NUM_REQ-1:0]   rot_req;
    logic                   gnt_found;
    logic [ID_W-1:0]        gnt_id;
    logic                   xfer;
    logic signed [13:0]     a_sel;
    logic [10:0]            b_sel;

    logic [NUM_STAGE-1:0]   vld_q;
    logic [ID_W-1:0]        id_q [NUM_STAGE];
    logic [20:0]            p_q  [NUM_STAGE];

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the first set bit wins.
    assign rot_req = {req_valid, req_valid} >> rr_ptr_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && rot_req[k]) begin
                gnt_found = 1'b1;
                if (int'(rr_ptr_q) + k >= NUM_REQ)
                    gnt_id = ID_W'(int'(rr_ptr_q) + k - NUM_REQ);
                else
                    gnt_id = ID_W'(int'(rr_ptr_q) + k);
            end
        end
    end

    assign xfer = gnt_found && ap_rst_n;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                req_ready[i] = xfer;
                a_sel        = $signed(req_a[14*i +: 14]);
                b_sel        = req_b[11*i +: 11];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer)
            rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    // Stage 1 captures the product of the granted lane; later stages shift without stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            for (int s = 0; s < NUM_STAGE; s++) begin
                id_q[s] <= '0;
                p_q[s]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q[0] <= xfer;
            if (xfer) begin
                id_q[0] <= gnt_id;
                p_q[0]  <= mul_wrap(a_sel, b_sel);
            end
            for (int s = 1; s < NUM_STAGE; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    id_q[s] <= id_q[s-1];
                    p_q[s]  <= p_q[s-1];
                end
            end
        end
    end

    // Output stage: id/product only load on valid, so they hold between strobes.
    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vld_q[LAST] && id_q[LAST] == ID_W'(i))
                res_valid[i] = 1'b1;
        end
    end

    assign res_id = id_q[LAST];
    assign res_p  = p_q[LAST];

`ifdef EXAMPLE_MUL_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] stats_cnt_q;
    logic [15:0] cnt_sel;

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stats_sel == ID_W'(i))
                cnt_sel = cnt_q[i];
        end
    end

    // Clear takes priority over a same-cycle accept.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stats_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                cnt_q[i] <= '0;
        end else begin
            stats_cnt_q <= cnt_sel;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr)
                    cnt_q[i] <= '0;
                else if (xfer && gnt_id == ID_W'(i) && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign stats_cnt = stats_cnt_q;
`endif

endmodule
